mode_switch_ctrl: RTL and testbench
===================================

// Module: mode_switch_ctrl
// PURPOSE
//   Parametrised N-channel mode controller for the piano top level. Selects one of
//   N_MODES mode engines (free/auto/learn/...) by one-hot select. Outputs are the
//   selected engine's note/led/num/octave.
//   Requires a new select to stay stable before it is accepted, then mutes output.
//   Then pulses a clear to the new engine and enables only that engine.
// PARAMETERS
//   N_MODES       3     number of mode engines (one-hot select width)
//   NOTE_W        4     note code width per channel
//   LED_W         7     led vector width per channel
//   NUM_W         4     display digit width per channel
//   OCT_W         2     octave width per channel
//   STABLE_CYCLES 16    cycles a new valid select must persist before acceptance (>=1)
//   MUTE_CYCLES   1000  cycles outputs held silent during a switch (>=1)
// PORTS
//   clk          in   1                clock
//   reset        in   1                synchronous, active-low reset
//   mode_sel     in   N_MODES          one-hot requested mode (raw switches)
//   note_in      in   N_MODES*NOTE_W   channel i at [i*NOTE_W +: NOTE_W]
//   led_in       in   N_MODES*LED_W    channel i at [i*LED_W +: LED_W]
//   num_in       in   N_MODES*NUM_W    channel i at [i*NUM_W +: NUM_W]
//   oct_in       in   N_MODES*OCT_W    channel i at [i*OCT_W +: OCT_W]
//   note_out     out  NOTE_W           note to buzzer driver, 0 = rest
//   led_out      out  LED_W            led vector
//   num_out      out  NUM_W            display digit
//   octave_out   out  OCT_W            octave of selected engine
//   mode_en      out  N_MODES          engine enables, one-hot or zero
//   mode_clr     out  N_MODES          one-cycle clear pulse to newly selected engine
//   active_mode  out  N_MODES          currently committed mode, one-hot or zero
//   busy         out  1                high while a switch is in progress
// BEHAVIOUR
//   Reset (reset==0 at posedge clk): state=IDLE. These are all 0: every output,
//     both counters, sel_q, and target.
//   Input stage: sel_q <= mode_sel each cycle. valid = sel_q has exactly one bit set.
//   Stability: stab_cnt resets to 0 when sel_q changes, otherwise saturates at
//     STABLE_CYCLES. "stable" = valid && stab_cnt==STABLE_CYCLES-1.
//   Accept: stable && sel_q != target is an accept event. Invalid selects
//     (zero or multi-hot) are never accepted; the current mode is retained.
//   States:
//     IDLE : no engine. mode_en=0, outputs 0. On accept: target<=sel_q, mute_cnt<=0,
//            go to MUTE.
//     MUTE : busy=1, mode_en=0. Outputs are silent: note/led/num=0.
//            octave_out holds its last value. mute_cnt increments.
//            On a new accept: target<=sel_q and mute_cnt<=0, staying in MUTE.
//            When mute_cnt==MUTE_CYCLES-1, go to CLEAR.
//     CLEAR: exactly 1 cycle. mode_clr=target, active_mode<=target, busy=1,
//            outputs still silent. Then go to RUN.
//     RUN  : busy=0, mode_clr=0, mode_en=active_mode.
//            Outputs <= channel[index(active_mode)], 1-cycle registered latency.
//            On accept: target<=sel_q, mute_cnt<=0, go to MUTE.
//   Timing from a mode_sel edge to first RUN output: 1 (sel_q) + STABLE_CYCLES
//     + MUTE_CYCLES + 1 (CLEAR) + 1 (output register) cycles.
//   Re-selecting the active mode while in RUN is not an accept; there is no glitch.
//   Returning to the old mode during MUTE is an accept (target differs),
//     so the full mute and clear sequence still runs.
//   Reset asserted mid-switch or mid-RUN: next cycle all reset values, state=IDLE.
//   Channel index decode is pure one-hot, with no priority encoding needed; the
//     RUN state guarantees active_mode is one-hot.
// TESTING
//   1. Reset low 3 cycles, then mode_sel=3'b100 held -> busy rises at cycle 18.
//      mode_clr=3'b100 for 1 cycle. note_out=note_in[11:8] by cycle 1+16+1000+2.
//   2. RUN on mode 0, mode_sel toggles 3'b001<->3'b010 every 5 cycles (STABLE=16)
//      -> no accept, busy stays 0, outputs track channel 0.
//   3. mode_sel=3'b011 or 3'b000 held 100 cycles in RUN -> active_mode unchanged, busy=0.
//   4. MUTE toward 3'b010, at mute_cnt=500 switch to 3'b100 -> mute restarts.
//      mode_clr=3'b100 only, never 3'b010.
//   5. reset low for 1 cycle during MUTE -> all outputs 0, state IDLE.
//      A held valid select re-triggers the full sequence.
//   6. In RUN on ch2, note_in[11:8] changes 4'd3->4'd7 -> note_out=7 exactly 1 cycle later.

Source files
------------

// File: rtl/mode_switch_ctrl.sv
// Mode switch controller: debounces a one-hot mode select, mutes the outputs
// while switching, pulses a clear into the newly chosen engine, then passes
// that engine's note/led/num/octave through a one-cycle output register.
module mode_switch_ctrl #(
  parameter int N_MODES       = 3,
  parameter int NOTE_W        = 4,
  parameter int LED_W         = 7,
  parameter int NUM_W         = 4,
  parameter int OCT_W         = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int MUTE_CYCLES   = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_MODES-1:0]        mode_sel,
  input  logic [N_MODES*NOTE_W-1:0] note_in,
  input  logic [N_MODES*LED_W-1:0]  led_in,
  input  logic [N_MODES*NUM_W-1:0]  num_in,
  input  logic [N_MODES*OCT_W-1:0]  oct_in,
  output logic [NOTE_W-1:0]         note_out,
  output logic [LED_W-1:0]          led_out,
  output logic [NUM_W-1:0]          num_out,
  output logic [OCT_W-1:0]          octave_out,
  output logic [N_MODES-1:0]        mode_en,
  output logic [N_MODES-1:0]        mode_clr,
  output logic [N_MODES-1:0]        active_mode,
  output logic                      busy
);

  // Counter widths leave room for the saturation value itself.
  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int MCW = $clog2(MUTE_CYCLES + 1);
  localparam logic [SCW-1:0] STAB_LAST = SCW'(STABLE_CYCLES - 1);
  localparam logic [SCW-1:0] STAB_MAX  = SCW'(STABLE_CYCLES);
  localparam logic [MCW-1:0] MUTE_LAST = MCW'(MUTE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUTE  = 2'd1,
    S_CLEAR = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [LED_W-1:0]  led;
    logic [NUM_W-1:0]  num;
    logic [OCT_W-1:0]  oct;
  } chan_t;

  state_t               state_q, state_d;
  logic [N_MODES-1:0]   sel_q;
  logic [SCW-1:0]       stab_cnt_q, stab_cnt_d;
  logic [MCW-1:0]       mute_cnt_q, mute_cnt_d;
  logic [N_MODES-1:0]   target_q, target_d;
  logic [N_MODES-1:0]   active_q, active_d;
  chan_t                out_q, out_d;
  chan_t                ch_sel;
  logic                 sel_valid;
  logic                 stable;
  logic                 accept;

  // Per-channel views of the flat input buses.
  logic [N_MODES-1:0][NOTE_W-1:0] note_ch;
  logic [N_MODES-1:0][LED_W-1:0]  led_ch;
  logic [N_MODES-1:0][NUM_W-1:0]  num_ch;
  logic [N_MODES-1:0][OCT_W-1:0]  oct_ch;

  for (genvar g = 0; g < N_MODES; g++) begin : g_ch
    assign note_ch[g] = note_in[g*NOTE_W +: NOTE_W];
    assign led_ch[g]  = led_in[g*LED_W +: LED_W];
    assign num_ch[g]  = num_in[g*NUM_W +: NUM_W];
    assign oct_ch[g]  = oct_in[g*OCT_W +: OCT_W];
  end

  // One-hot AND-OR mux: active_q is one-hot in RUN, so no priority is needed.
  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < N_MODES; i++) begin
      if (active_q[i]) begin
        ch_sel.note = ch_sel.note | note_ch[i];
        ch_sel.led  = ch_sel.led  | led_ch[i];
        ch_sel.num  = ch_sel.num  | num_ch[i];
        ch_sel.oct  = ch_sel.oct  | oct_ch[i];
      end
    end
  end

  assign sel_valid = $onehot(sel_q);
  assign stable    = sel_valid && (stab_cnt_q == STAB_LAST);
  assign accept    = stable && (sel_q != target_q);

  // Stability counter: restarts whenever the registered select is about to change.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (mode_sel != sel_q)           stab_cnt_d = '0;
    else if (stab_cnt_q != STAB_MAX) stab_cnt_d = stab_cnt_q + SCW'(1);
  end

  // Next-state and output decode; outputs are silent unless staying in RUN.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    mute_cnt_d = mute_cnt_q;
    active_d   = active_q;
    out_d      = '{note: '0, led: '0, num: '0, oct: out_q.oct};
    busy       = 1'b0;
    mode_clr   = '0;
    mode_en    = '0;
    case (state_q)
      S_IDLE: begin
        out_d = '0;
        if (accept) begin
          target_d   = sel_q;
          mute_cnt_d = '0;
          state_d    = S_MUTE;
        end
      end
      S_MUTE: begin
        busy = 1'b1;
        if (accept) begin
          target_d   = sel_q;
          mute_cnt_d = '0;
        end else if (mute_cnt_q == MUTE_LAST) begin
          state_d = S_CLEAR;
        end else begin
          mute_cnt_d = mute_cnt_q + MCW'(1);
        end
      end
      S_CLEAR: begin
        busy     = 1'b1;
        mode_clr = target_q;
        active_d = target_q;
        state_d  = S_RUN;
      end
      S_RUN: begin
        mode_en = active_q;
        if (accept) begin
          target_d   = sel_q;
          mute_cnt_d = '0;
          state_d    = S_MUTE;
        end else begin
          out_d = ch_sel;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      stab_cnt_q <= '0;
      mute_cnt_q <= '0;
      target_q   <= '0;
      active_q   <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= mode_sel;
      stab_cnt_q <= stab_cnt_d;
      mute_cnt_q <= mute_cnt_d;
      target_q   <= target_d;
      active_q   <= active_d;
      out_q      <= out_d;
    end
  end

  assign note_out    = out_q.note;
  assign led_out     = out_q.led;
  assign num_out     = out_q.num;
  assign octave_out  = out_q.oct;
  assign active_mode = active_q;

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Scoreboard bench for mode_switch_ctrl: a behavioural model pushes the
// expected outputs on every clock edge; a negedge monitor pops and compares.
module tb_mode_switch_ctrl;
  localparam int NM     = 3;
  localparam int NOTE_W = 4;
  localparam int LED_W  = 7;
  localparam int NUM_W  = 4;
  localparam int OCT_W  = 2;
  localparam int STABLE = 16;
  localparam int MUTE   = 1000;
  localparam int EW     = NOTE_W + LED_W + NUM_W + OCT_W + 3*NM + 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NM-1:0]            mode_sel;
  logic [NM*NOTE_W-1:0]     note_in;
  logic [NM*LED_W-1:0]      led_in;
  logic [NM*NUM_W-1:0]      num_in;
  logic [NM*OCT_W-1:0]      oct_in;
  logic [NOTE_W-1:0]        note_out;
  logic [LED_W-1:0]         led_out;
  logic [NUM_W-1:0]         num_out;
  logic [OCT_W-1:0]         octave_out;
  logic [NM-1:0]            mode_en, mode_clr, active_mode;
  logic                     busy;

  mode_switch_ctrl #(
    .N_MODES(NM), .NOTE_W(NOTE_W), .LED_W(LED_W), .NUM_W(NUM_W), .OCT_W(OCT_W),
    .STABLE_CYCLES(STABLE), .MUTE_CYCLES(MUTE)
  ) dut (
    .clk(clk), .reset(reset), .mode_sel(mode_sel),
    .note_in(note_in), .led_in(led_in), .num_in(num_in), .oct_in(oct_in),
    .note_out(note_out), .led_out(led_out), .num_out(num_out), .octave_out(octave_out),
    .mode_en(mode_en), .mode_clr(mode_clr), .active_mode(active_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [EW-1:0] expq[$];
  bit rand_data = 0;

  // Behavioural model: switch progress as flags plus a countdown of mute cycles.
  logic [NM-1:0]     m_sel, m_tgt, m_active;
  int                m_age, m_left;
  bit                m_muting, m_clear, m_run;
  logic [NOTE_W-1:0] m_note;
  logic [LED_W-1:0]  m_led;
  logic [NUM_W-1:0]  m_num;
  logic [OCT_W-1:0]  m_oct;

  task automatic model_step();
    bit acc;
    int k;
    if (!reset) begin
      m_sel = '0; m_tgt = '0; m_active = '0; m_age = 0; m_left = 0;
      m_muting = 0; m_clear = 0; m_run = 0;
      m_note = '0; m_led = '0; m_num = '0; m_oct = '0;
      return;
    end
    acc = ($countones(m_sel) == 1) && (m_age == STABLE - 1) && (m_sel != m_tgt);
    if (m_run && !acc) begin
      k = 0;
      for (int i = 0; i < NM; i++) if (m_active[i]) k = i;
      m_note = note_in[k*NOTE_W +: NOTE_W];
      m_led  = led_in[k*LED_W +: LED_W];
      m_num  = num_in[k*NUM_W +: NUM_W];
      m_oct  = oct_in[k*OCT_W +: OCT_W];
    end else begin
      m_note = '0; m_led = '0; m_num = '0;
    end
    if (m_clear) begin
      m_active = m_tgt; m_clear = 0; m_run = 1;
    end else if (acc) begin
      m_tgt = m_sel; m_left = MUTE; m_muting = 1; m_run = 0;
    end else if (m_muting) begin
      m_left--;
      if (m_left == 0) begin m_muting = 0; m_clear = 1; end
    end
    if (mode_sel != m_sel) m_age = 0;
    else if (m_age < STABLE) m_age++;
    m_sel = mode_sel;
  endtask

  function automatic logic [EW-1:0] model_out();
    return {m_note, m_led, m_num, m_oct,
            (m_run ? m_active : {NM{1'b0}}),
            (m_clear ? m_tgt : {NM{1'b0}}),
            m_active, (m_muting || m_clear)};
  endfunction

  // One clock: optional fresh channel data, edge, model update, expectation push.
  task automatic tick();
    if (rand_data) begin
      note_in = NM*NOTE_W'($urandom);
      led_in  = NM*LED_W'($urandom);
      num_in  = NM*NUM_W'($urandom);
      oct_in  = NM*OCT_W'($urandom);
    end
    @(posedge clk);
    model_step();
    expq.push_back(model_out());
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set.
  always @(negedge clk) begin
    logic [EW-1:0] e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {note_out, led_out, num_out, octave_out, mode_en, mode_clr, active_mode, busy};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got %h want %h (note,led,num,oct,en,clr,act,busy)",
                 $time, a, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n100, n010, dur;
    reset = 1'b0; mode_sel = '0;
    note_in = 12'h359; led_in = 21'h0A5C3; num_in = 12'h618; oct_in = 6'b10_01_11;

    // Reset held three cycles: all outputs zero.
    repeat (3) tick();
    chk("reset_state", 32'({note_out, led_out, num_out, octave_out, mode_en, mode_clr,
                            active_mode, busy}), 32'd0);

    // 1: select channel 2 from reset, check the switch timeline.
    reset = 1'b1; mode_sel = 3'b100;
    repeat (16) tick();
    chk("t1_busy_before", 32'(busy), 32'd0);
    tick();
    chk("t1_busy_rise", 32'(busy), 32'd1);
    repeat (MUTE) tick();
    chk("t1_clr_pulse", 32'(mode_clr), 32'b100);
    tick();
    chk("t1_clr_off", 32'(mode_clr), 32'd0);
    chk("t1_en", 32'(mode_en), 32'b100);
    chk("t1_note_silent", 32'(note_out), 32'd0);
    tick();
    chk("t1_note", 32'(note_out), 32'd3);
    chk("t1_oct", 32'(octave_out), 32'd2);

    // 2: run on channel 0, then bounce between 001/010 faster than the debounce.
    rand_data = 1; mode_sel = 3'b001;
    repeat (1030) tick();
    chk("t2_active", 32'(active_mode), 32'b001);
    for (int i = 0; i < 12; i++) begin
      mode_sel = mode_sel ^ 3'b011;
      repeat (5) tick();
      chk("t2_busy_toggle", 32'(busy), 32'd0);
    end
    repeat (30) tick();
    chk("t2_active_kept", 32'(active_mode), 32'b001);

    // 3: invalid selects are never accepted.
    mode_sel = 3'b011; repeat (100) tick();
    chk("t3_multihot_act", 32'(active_mode), 32'b001);
    chk("t3_multihot_busy", 32'(busy), 32'd0);
    mode_sel = 3'b000; repeat (100) tick();
    chk("t3_zero_act", 32'(active_mode), 32'b001);
    chk("t3_zero_busy", 32'(busy), 32'd0);

    // 4: retarget mid-mute; only the final target sees a clear.
    mode_sel = 3'b010; repeat (STABLE + 1 + 500) tick();
    chk("t4_muting", 32'(busy), 32'd1);
    mode_sel = 3'b100; n100 = 0; n010 = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (mode_clr == 3'b100) n100++;
      if (mode_clr == 3'b010) n010++;
    end
    chk("t4_clr_100", 32'(n100), 32'd1);
    chk("t4_clr_010", 32'(n010), 32'd0);
    chk("t4_active", 32'(active_mode), 32'b100);

    // 5: reset pulse during mute, then the held select restarts the sequence.
    mode_sel = 3'b001; repeat (STABLE + 1 + 300) tick();
    reset = 1'b0; tick();
    chk("t5_reset_outs", 32'({note_out, led_out, num_out, octave_out, mode_en, mode_clr,
                              active_mode, busy}), 32'd0);
    reset = 1'b1;
    repeat (1 + STABLE + MUTE + 2) tick();
    chk("t5_active", 32'(active_mode), 32'b001);
    chk("t5_en", 32'(mode_en), 32'b001);

    // 6: in RUN on channel 2, a note change appears exactly one cycle later.
    mode_sel = 3'b100; repeat (1030) tick();
    rand_data = 0;
    note_in[11:8] = 4'd3; tick(); tick();
    chk("t6_note3", 32'(note_out), 32'd3);
    note_in[11:8] = 4'd7; tick();
    chk("t6_note7", 32'(note_out), 32'd7);

    // Random selects, hold times and occasional resets.
    rand_data = 1;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) mode_sel = NM'($urandom_range(0, 7));
      else mode_sel = NM'(1 << $urandom_range(0, NM - 1));
      if ($urandom_range(0, 2) == 0) dur = $urandom_range(1, 30);
      else dur = $urandom_range(STABLE + 1, 1100);
      repeat (dur) tick();
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b0; tick(); reset = 1'b1;
      end
    end

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
